// File: rtl/node_merge_sync.sv
// 4-way controlled merge: one control token selects which input is forwarded.
// The selected input token is pushed into a small registered output FIFO.
module node_merge_sync #(
    parameter int W     = 11,
    parameter int CW    = 3,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ctrl_valid,
    input  logic [CW-1:0] ctrl_data,
    output logic          ctrl_ready,
    input  logic          in1_valid,
    input  logic [W-1:0]  in1_data,
    output logic          in1_ready,
    input  logic          in2_valid,
    input  logic [W-1:0]  in2_data,
    output logic          in2_ready,
    input  logic          in3_valid,
    input  logic [W-1:0]  in3_data,
    output logic          in3_ready,
    input  logic          in4_valid,
    input  logic [W-1:0]  in4_data,
    output logic          in4_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic [1:0]   sel;
    logic [3:0]   in_valid;
    logic [3:0]   in_rdy;
    logic [W-1:0] sel_data;
    logic         full;
    logic         fire;
    logic         pop;
    logic         unused_ctrl;

    // Upper control bits only alias; they never affect selection.
    assign unused_ctrl = ^ctrl_data;

    assign sel      = ctrl_data[1:0];
    assign in_valid = {in4_valid, in3_valid, in2_valid, in1_valid};
    assign full     = (cnt_q == FULL_CNT);

    always_comb begin
        sel_data = '0;
        unique case (sel)
            2'd0: sel_data = in1_data;
            2'd1: sel_data = in2_data;
            2'd2: sel_data = in3_data;
            2'd3: sel_data = in4_data;
        endcase
    end

    // Full is judged before any pop, so out_ready never reaches the readies.
    assign fire = ~reset & ctrl_valid & in_valid[sel] & ~full;
    assign pop  = ~reset & out_valid & out_ready;

    assign in_rdy     = fire ? (4'b0001 << sel) : 4'b0000;
    assign ctrl_ready = fire;
    assign in1_ready  = in_rdy[0];
    assign in2_ready  = in_rdy[1];
    assign in3_ready  = in_rdy[2];
    assign in4_ready  = in_rdy[3];

    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (fire) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(fire) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (fire) begin
                mem_q[wr_q] <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_node_merge_sync.sv
// Directed bench for node_merge_sync: control/data joint consumption,
// aliasing, backpressure, reset flush and a randomised ordering run.
module tb_node_merge_sync;

    localparam int W = 11;
    localparam int CW = 3;
    localparam int DEPTH = 2;

    logic          clk;
    logic          reset;
    logic          ctrl_valid;
    logic [CW-1:0] ctrl_data;
    logic          ctrl_ready;
    logic          in1_valid, in2_valid, in3_valid, in4_valid;
    logic [W-1:0]  in1_data, in2_data, in3_data, in4_data;
    logic          in1_ready, in2_ready, in3_ready, in4_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;

    node_merge_sync #(.W(W), .CW(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ctrl_valid(ctrl_valid), .ctrl_data(ctrl_data),
        .ctrl_ready(ctrl_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready),
        .in3_valid(in3_valid), .in3_data(in3_data), .in3_ready(in3_ready),
        .in4_valid(in4_valid), .in4_data(in4_data), .in4_ready(in4_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0]  ind [4];
    bit            iv [4];
    bit            auto_inc [4];
    logic [CW-1:0] ctrl_q [$];
    logic [W-1:0]  got [$];
    logic [W-1:0]  exp_q [$];
    int            acc [4];
    int            ctrl_cnt;
    logic          last_cr;
    logic [3:0]    last_rdy;

    task automatic drive();
        ctrl_valid = (ctrl_q.size() > 0);
        ctrl_data  = (ctrl_q.size() > 0) ? ctrl_q[0] : '0;
        in1_valid = iv[0]; in1_data = ind[0];
        in2_valid = iv[1]; in2_data = ind[1];
        in3_valid = iv[2]; in3_data = ind[2];
        in4_valid = iv[3]; in4_data = ind[3];
    endtask

    // One clock: present, sample handshakes, clock, then update senders.
    task automatic cycle();
        logic [3:0] rdy;
        logic       hs_c;
        drive();
        #1;
        rdy = {in4_ready, in3_ready, in2_ready, in1_ready};
        hs_c = ctrl_ready;
        last_cr = ctrl_ready;
        last_rdy = rdy;
        if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
        @(posedge clk);
        #1;
        if (hs_c === 1'b1) begin
            ctrl_cnt++;
            if (ctrl_q.size() > 0) void'(ctrl_q.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
            if (rdy[k] === 1'b1) begin
                acc[k]++;
                if (auto_inc[k]) ind[k] = ind[k] + 1'b1;
            end
        end
    endtask

    task automatic clear_stats();
        got.delete();
        exp_q.delete();
        for (int k = 0; k < 4; k++) acc[k] = 0;
        ctrl_cnt = 0;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int i = 0; i < budget && got.size() < n; i++) cycle();
        n_chk++;
        if (got.size() != n) begin
            n_fail++;
            $display("FAIL drain_count: got %0d tokens, want %0d", got.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b1; ind[k] = W'(k + 1); auto_inc[k] = 1'b0;
        end
        ctrl_q.push_back(3'd0);
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_chk++;
            if (out_valid !== 1'b0 || last_cr !== 1'b0 || last_rdy !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: ov=%b cr=%b rdy=%b want 0/0/0",
                         c, out_valid, last_cr, last_rdy);
            end
        end
        n_chk++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%h want 0", out_data);
        end
        ctrl_q.delete();
        for (int k = 0; k < 4; k++) iv[k] = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cycle();
            n_chk++;
            if (out_valid !== 1'b0 || last_cr !== 1'b0 || last_rdy !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: ov=%b cr=%b rdy=%b want 0/0/0",
                         c, out_valid, last_cr, last_rdy);
            end
        end
    endtask

    task automatic test_round_robin();
        clear_stats();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b1; ind[k] = W'(1); auto_inc[k] = 1'b1;
        end
        ctrl_q = '{3'd0, 3'd1, 3'd2, 3'd3};
        cycle();
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== W'(1)) begin
            n_fail++;
            $display("FAIL latency: ov=%b data=%h want 1/001", out_valid, out_data);
        end
        for (int c = 0; c < 3; c++) cycle();
        n_chk++;
        if (ctrl_q.size() != 0) begin
            n_fail++;
            $display("FAIL throughput: %0d ctrl left after 4 cycles, want 0", ctrl_q.size());
        end
        run_until(4, 10);
        for (int i = 0; i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== W'(1)) begin
                n_fail++;
                $display("FAIL rr_data[%0d]: %h want 001", i, got[i]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (acc[k] != 1) begin
                n_fail++;
                $display("FAIL rr_consume in%0d: %0d accepts want 1", k + 1, acc[k]);
            end
        end
    endtask

    task automatic test_repeat_sel();
        clear_stats();
        out_ready = 1'b1;
        ind[0] = W'(11'h011); ind[1] = W'(11'h022);
        ind[2] = W'(7);       ind[3] = W'(11'h044);
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b1; auto_inc[k] = (k == 2);
        end
        ctrl_q = '{3'd2, 3'd2, 3'd2};
        run_until(3, 12);
        exp_q = '{W'(7), W'(8), W'(9)};
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rep_data[%0d]: %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_chk++;
        if (acc[0] != 0 || acc[1] != 0 || acc[3] != 0 || acc[2] != 3) begin
            n_fail++;
            $display("FAIL rep_consume: acc=%0d/%0d/%0d/%0d want 0/0/3/0",
                     acc[0], acc[1], acc[2], acc[3]);
        end
    endtask

    task automatic test_alias();
        clear_stats();
        out_ready = 1'b1;
        ind[0] = W'(11'h001); ind[1] = W'(11'h3FF);
        ind[2] = W'(11'h0AA); ind[3] = W'(11'h155);
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b1; auto_inc[k] = 1'b0;
        end
        ctrl_q = '{3'd5, 3'd7};
        run_until(2, 10);
        exp_q = '{W'(11'h3FF), W'(11'h155)};
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL alias[%0d]: %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_chk++;
        if (acc[0] != 0 || acc[1] != 1 || acc[2] != 0 || acc[3] != 1) begin
            n_fail++;
            $display("FAIL alias_consume: acc=%0d/%0d/%0d/%0d want 0/1/0/1",
                     acc[0], acc[1], acc[2], acc[3]);
        end
    endtask

    task automatic test_backpressure();
        clear_stats();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b1; auto_inc[k] = 1'b1; ind[k] = W'(100 * (k + 1));
        end
        ctrl_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
        exp_q = '{W'(100), W'(200), W'(300), W'(400),
                  W'(101), W'(201), W'(301), W'(401)};
        for (int c = 0; c < 5; c++) cycle();
        n_chk++;
        if (ctrl_cnt != DEPTH) begin
            n_fail++;
            $display("FAIL bp_accepts: %0d want %0d", ctrl_cnt, DEPTH);
        end
        n_chk++;
        if (last_cr !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ctrl_ready: %b want 0", last_cr);
        end
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== W'(100)) begin
            n_fail++;
            $display("FAIL bp_head: ov=%b data=%h want 1/064", out_valid, out_data);
        end
        out_ready = 1'b1;
        run_until(8, 40);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_data[%0d]: %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_flush();
        logic [W-1:0] mdl [4];
        int bad;
        clear_stats();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b1; auto_inc[k] = 1'b1; ind[k] = W'(16 * (k + 1));
        end
        ctrl_q = '{3'd0, 3'd1, 3'd2};
        for (int c = 0; c < 3; c++) cycle();
        n_chk++;
        if (ctrl_cnt != 2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_fill: accepts=%0d ov=%b want 2/1", ctrl_cnt, out_valid);
        end
        reset = 1'b1;
        cycle();
        n_chk++;
        if (last_cr !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL flush: cr=%b ov=%b data=%h want 0/0/000",
                     last_cr, out_valid, out_data);
        end
        reset = 1'b0;
        clear_stats();
        ctrl_q.delete();
        out_ready = 1'b1;
        ctrl_q = '{3'd3, 3'd2, 3'd1, 3'd0};
        exp_q = '{ind[3], ind[2], ind[1], ind[0]};
        run_until(4, 12);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL flush_seq[%0d]: %h want %h", i, got[i], exp_q[i]);
            end
        end
        clear_stats();
        for (int k = 0; k < 4; k++) mdl[k] = ind[k];
        for (int i = 0; i < 1000; i++) begin
            logic [1:0] s;
            s = 2'($urandom_range(3));
            ctrl_q.push_back({1'b0, s});
            exp_q.push_back(mdl[s]);
            mdl[s] = mdl[s] + 1'b1;
        end
        for (int c = 0; c < 6000 && got.size() < 1000; c++) begin
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end
        out_ready = 1'b1;
        n_chk++;
        if (got.size() != 1000) begin
            n_fail++;
            $display("FAIL rand_count: %0d want 1000", got.size());
        end
        bad = 0;
        for (int i = 0; i < got.size() && i < 1000; i++) begin
            n_chk++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_data[%0d]: %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0; ind[k] = '0; auto_inc[k] = 1'b0; acc[k] = 0;
        end
        ctrl_cnt = 0;
        drive();
        #1;
        test_reset();
        test_round_robin();
        test_repeat_sel();
        test_alias();
        test_backpressure();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
